// File: rtl/fifo_merge_cell_if.sv
// Handshake bundle between the merge cell and its two upstream FIFOs and one downstream FIFO.
interface fifo_merge_cell_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a_dout;
    logic             a_empty;
    logic             a_deq;
    logic [WIDTH-1:0] b_dout;
    logic             b_empty;
    logic             b_deq;
    logic [WIDTH-1:0] out_din;
    logic             out_enq;
    logic             out_full;
    logic             out_last;

    // The merge cell side: pops the input FIFOs and pushes the output FIFO.
    modport master (
        input  a_dout, a_empty, b_dout, b_empty, out_full,
        output a_deq, b_deq, out_din, out_enq, out_last
    );

    // The FIFO side: presents heads and flags, and receives the strobes.
    modport slave (
        output a_dout, a_empty, b_dout, b_empty, out_full,
        input  a_deq, b_deq, out_din, out_enq, out_last
    );
endinterface

// File: rtl/fifo_merge_cell.sv
// Merge stage of the hardware sorter: merges two ascending runs of RUN_LEN
// elements into one ascending run of 2*RUN_LEN, one element per cycle at most.
module fifo_merge_cell #(
    parameter int WIDTH   = 32,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    fifo_merge_cell_if.master bus
);

    typedef enum logic [1:0] {
        MERGE   = 2'd0,
        DRAIN_A = 2'd1,
        DRAIN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] RUN_END = CNT_W'(RUN_LEN);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic [CNT_W-1:0] cnt_a_nxt, cnt_b_nxt;
    logic [CNT_W-1:0] cnt_a_inc, cnt_b_inc;
    logic             pick_a;

    assign cnt_a_inc = cnt_a + CNT_W'(1);
    assign cnt_b_inc = cnt_b + CNT_W'(1);

    // In MERGE the smaller head wins, ties go to A so equal keys keep port order.
    always_comb begin
        pick_a = 1'b1;
        case (state)
            MERGE:   pick_a = (bus.a_dout <= bus.b_dout);
            DRAIN_B: pick_a = 1'b0;
            default: pick_a = 1'b1;
        endcase
    end

    // Next-state, counter and handshake logic; nothing fires while rst is high.
    always_comb begin
        state_nxt    = state;
        cnt_a_nxt    = cnt_a;
        cnt_b_nxt    = cnt_b;
        bus.a_deq    = 1'b0;
        bus.b_deq    = 1'b0;
        bus.out_enq  = 1'b0;
        bus.out_last = 1'b0;
        bus.out_din  = pick_a ? bus.a_dout : bus.b_dout;
        if (!rst && !bus.out_full) begin
            case (state)
                MERGE: begin
                    // Both heads are needed before the smaller one is known.
                    if (!bus.a_empty && !bus.b_empty) begin
                        bus.out_enq = 1'b1;
                        if (pick_a) begin
                            bus.a_deq = 1'b1;
                            cnt_a_nxt = cnt_a_inc;
                            if (cnt_a_inc == RUN_END) state_nxt = DRAIN_B;
                        end else begin
                            bus.b_deq = 1'b1;
                            cnt_b_nxt = cnt_b_inc;
                            if (cnt_b_inc == RUN_END) state_nxt = DRAIN_A;
                        end
                    end
                end
                DRAIN_A: begin
                    if (!bus.a_empty) begin
                        bus.out_enq = 1'b1;
                        bus.a_deq   = 1'b1;
                        cnt_a_nxt   = cnt_a_inc;
                        if (cnt_a_inc == RUN_END) begin
                            bus.out_last = 1'b1;
                            cnt_a_nxt    = '0;
                            cnt_b_nxt    = '0;
                            state_nxt    = MERGE;
                        end
                    end
                end
                DRAIN_B: begin
                    if (!bus.b_empty) begin
                        bus.out_enq = 1'b1;
                        bus.b_deq   = 1'b1;
                        cnt_b_nxt   = cnt_b_inc;
                        if (cnt_b_inc == RUN_END) begin
                            bus.out_last = 1'b1;
                            cnt_a_nxt    = '0;
                            cnt_b_nxt    = '0;
                            state_nxt    = MERGE;
                        end
                    end
                end
                default: begin
                    state_nxt = MERGE;
                    cnt_a_nxt = '0;
                    cnt_b_nxt = '0;
                end
            endcase
        end
    end

    // State and run counters; a reset mid-run throws the partial run away.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MERGE;
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            state <= state_nxt;
            cnt_a <= cnt_a_nxt;
            cnt_b <= cnt_b_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_merge_cell.sv
// Directed bench for fifo_merge_cell: queues stand in for the FIFOs, each test checks inline.
module tb_fifo_merge_cell;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_merge_cell_if #(.WIDTH(32)) bus ();

    fifo_merge_cell #(.WIDTH(32), .RUN_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] out_q[$];
    bit          last_q[$];
    bit          src_a_q[$];

    bit a_gate = 0, b_gate = 0, full_gate = 0, rand_gates = 0;
    bit s_a_deq, s_b_deq, s_enq, s_last;

    // Present queue heads/flags, sample outputs mid-cycle, then pop on the edge.
    task automatic tick();
        bit pa, pb;
        if (rand_gates) begin
            a_gate    = 1'($urandom_range(0, 1));
            b_gate    = 1'($urandom_range(0, 1));
            full_gate = ($urandom_range(0, 3) == 0);
        end
        bus.a_empty  = a_gate || (qa.size() == 0);
        bus.a_dout   = (qa.size() != 0) ? qa[0] : 32'd0;
        bus.b_empty  = b_gate || (qb.size() == 0);
        bus.b_dout   = (qb.size() != 0) ? qb[0] : 32'd0;
        bus.out_full = full_gate;
        #2;
        s_a_deq = bus.a_deq;
        s_b_deq = bus.b_deq;
        s_enq   = bus.out_enq;
        s_last  = bus.out_last;
        if (s_enq) begin
            out_q.push_back(bus.out_din);
            last_q.push_back(s_last);
            src_a_q.push_back(s_a_deq);
        end
        pa = s_a_deq && qa.size() != 0;
        pb = s_b_deq && qb.size() != 0;
        @(posedge clk);
        #1;
        if (pa) void'(qa.pop_front());
        if (pb) void'(qb.pop_front());
    endtask

    task automatic run_until(input int n, input int budget, output int cycles, output bit timeout);
        cycles = 0;
        while (out_q.size() < n && cycles < budget) begin
            tick();
            cycles++;
        end
        timeout = (out_q.size() < n);
    endtask

    task automatic clear_all();
        qa.delete(); qb.delete(); out_q.delete(); last_q.delete(); src_a_q.delete();
        a_gate = 0; b_gate = 0; full_gate = 0; rand_gates = 0;
    endtask

    task automatic test_reset();
        clear_all();
        qa = '{32'd5, 32'd6}; qb = '{32'd1, 32'd2};
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({s_a_deq, s_b_deq, s_enq, s_last} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got deqA/deqB/enq/last=%b expected 0000",
                     {s_a_deq, s_b_deq, s_enq, s_last});
        end
        tick();
        rst = 1'b0;
        n_cmp++;
        if (dut.state !== 2'd0 || dut.cnt_a !== 3'd0 || dut.cnt_b !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got state=%0d cnt_a=%0d cnt_b=%0d expected 0/0/0",
                     dut.state, dut.cnt_a, dut.cnt_b);
        end
        n_cmp++;
        if (qa.size() != 2 || qb.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL reset_no_pop: got sizes A=%0d B=%0d expected 2/2", qa.size(), qb.size());
        end
        clear_all();
    endtask

    task automatic test_interleave();
        logic [31:0] exp_v[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
        int cyc; bit to;
        clear_all();
        qa = '{32'd1, 32'd3, 32'd5, 32'd7}; qb = '{32'd2, 32'd4, 32'd6, 32'd8};
        run_until(8, 40, cyc, to);
        n_cmp++;
        if (to || cyc != 8) begin
            n_fail++;
            $display("[TB] FAIL interleave_cycles: got %0d cycles (timeout=%0d) expected 8", cyc, to);
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== exp_v[i] || last_q[i] !== (i == 7)) begin
                n_fail++;
                $display("[TB] FAIL interleave_out[%0d]: got %0d last=%0d expected %0d last=%0d",
                         i, out_q[i], last_q[i], exp_v[i], (i == 7));
            end
        end
        n_cmp++;
        if (dut.state !== 2'd0 || dut.cnt_a !== 3'd0 || dut.cnt_b !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL interleave_end_state: got state=%0d cnt_a=%0d cnt_b=%0d expected 0/0/0",
                     dut.state, dut.cnt_a, dut.cnt_b);
        end
    endtask

    task automatic test_sequential();
        int cyc; bit to;
        clear_all();
        qa = '{32'd1, 32'd2, 32'd3, 32'd4}; qb = '{32'd5, 32'd6, 32'd7, 32'd8};
        run_until(8, 40, cyc, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("[TB] FAIL sequential_timeout: got %0d outputs expected 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== 32'(i + 1) || src_a_q[i] !== (i < 4) || last_q[i] !== (i == 7)) begin
                n_fail++;
                $display("[TB] FAIL sequential_out[%0d]: got %0d fromA=%0d last=%0d expected %0d fromA=%0d last=%0d",
                         i, out_q[i], src_a_q[i], last_q[i], i + 1, (i < 4), (i == 7));
            end
        end
    endtask

    task automatic test_ties();
        int cyc; bit to;
        clear_all();
        qa = '{32'd2, 32'd2, 32'd2, 32'd2}; qb = '{32'd2, 32'd2, 32'd2, 32'd2};
        run_until(8, 40, cyc, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("[TB] FAIL ties_timeout: got %0d outputs expected 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== 32'd2 || src_a_q[i] !== (i < 4)) begin
                n_fail++;
                $display("[TB] FAIL ties_src[%0d]: got val=%0d fromA=%0d expected val=2 fromA=%0d",
                         i, out_q[i], src_a_q[i], (i < 4));
            end
        end
    endtask

    task automatic test_b_late();
        logic [31:0] exp_v[8] = '{0, 1, 2, 3, 10, 11, 12, 13};
        int cyc; bit to;
        clear_all();
        qa = '{32'd10, 32'd11, 32'd12, 32'd13}; qb = '{32'd0, 32'd1, 32'd2, 32'd3};
        b_gate = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({s_a_deq, s_b_deq, s_enq} !== 3'b000) begin
                n_fail++;
                $display("[TB] FAIL b_late_wait[%0d]: got deqA/deqB/enq=%b expected 000",
                         i, {s_a_deq, s_b_deq, s_enq});
            end
        end
        b_gate = 0;
        run_until(8, 40, cyc, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("[TB] FAIL b_late_timeout: got %0d outputs expected 8", out_q.size());
        end
        n_cmp++;
        if (out_q.size() == 0 || out_q[0] !== 32'd0 || src_a_q[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b_late_first: got %0d outputs first=%0d expected first 0 from B",
                     out_q.size(), (out_q.size() != 0) ? out_q[0] : 32'hFFFF_FFFF);
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== exp_v[i] || last_q[i] !== (i == 7)) begin
                n_fail++;
                $display("[TB] FAIL b_late_out[%0d]: got %0d last=%0d expected %0d last=%0d",
                         i, out_q[i], last_q[i], exp_v[i], (i == 7));
            end
        end
    endtask

    task automatic test_full_stall();
        int cyc; bit to;
        clear_all();
        qa = '{32'd1, 32'd3, 32'd5, 32'd7}; qb = '{32'd2, 32'd4, 32'd6, 32'd8};
        for (int i = 0; i < 3; i++) tick();
        full_gate = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({s_a_deq, s_b_deq, s_enq} !== 3'b000 || dut.cnt_a !== 3'd2 || dut.cnt_b !== 3'd1) begin
                n_fail++;
                $display("[TB] FAIL full_stall[%0d]: got deqA/deqB/enq=%b cnt_a=%0d cnt_b=%0d expected 000 2 1",
                         i, {s_a_deq, s_b_deq, s_enq}, dut.cnt_a, dut.cnt_b);
            end
        end
        full_gate = 0;
        run_until(8, 40, cyc, to);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= out_q.size() || out_q[i] !== 32'(i + 1) || last_q[i] !== (i == 7)) begin
                n_fail++;
                $display("[TB] FAIL full_resume[%0d]: got %0d of %0d outputs value=%0d expected %0d",
                         i, i, out_q.size(), (i < out_q.size()) ? out_q[i] : 32'hFFFF_FFFF, i + 1);
            end
        end
    endtask

    task automatic test_random_empty();
        logic [31:0] exp_v[8] = '{1, 3, 9, 9, 9, 15, 20, 30};
        int cyc; bit to;
        clear_all();
        qa = '{32'd3, 32'd9, 32'd9, 32'd20}; qb = '{32'd1, 32'd9, 32'd15, 32'd30};
        rand_gates = 1;
        run_until(8, 400, cyc, to);
        clear_gates_only();
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("[TB] FAIL random_timeout: got %0d outputs expected 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== exp_v[i] || last_q[i] !== (i == 7)) begin
                n_fail++;
                $display("[TB] FAIL random_out[%0d]: got %0d last=%0d expected %0d last=%0d",
                         i, out_q[i], last_q[i], exp_v[i], (i == 7));
            end
        end
    endtask

    task automatic clear_gates_only();
        rand_gates = 0; a_gate = 0; b_gate = 0; full_gate = 0;
    endtask

    task automatic test_mid_reset();
        int cyc; bit to;
        clear_all();
        qa = '{32'd1, 32'd3, 32'd5, 32'd7}; qb = '{32'd2, 32'd4, 32'd6, 32'd8};
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_all();
        n_cmp++;
        if (dut.state !== 2'd0 || dut.cnt_a !== 3'd0 || dut.cnt_b !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_state: got state=%0d cnt_a=%0d cnt_b=%0d expected 0/0/0",
                     dut.state, dut.cnt_a, dut.cnt_b);
        end
        qa = '{32'd4, 32'd5, 32'd6, 32'd7}; qb = '{32'd1, 32'd2, 32'd3, 32'd8};
        run_until(8, 40, cyc, to);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= out_q.size() || out_q[i] !== 32'(i + 1) || last_q[i] !== (i == 7)) begin
                n_fail++;
                $display("[TB] FAIL mid_reset_out[%0d]: got %0d outputs value=%0d last=%0d expected %0d last=%0d",
                         i, out_q.size(), (i < out_q.size()) ? out_q[i] : 32'hFFFF_FFFF,
                         (i < out_q.size()) ? last_q[i] : 1'b0, i + 1, (i == 7));
            end
        end
    endtask

    // Runs every scenario in order and prints the tally.
    initial begin
        bus.a_dout = '0; bus.a_empty = 1'b1;
        bus.b_dout = '0; bus.b_empty = 1'b1;
        bus.out_full = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_interleave();
        test_sequential();
        test_ties();
        test_b_late();
        test_full_stall();
        test_random_empty();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
